mem_port_arbiter: RTL and testbench

//   Shares the single 32-bit memory port between instruction fetch (I) and load/store (D).

---
 rtl/mem_port_arbiter.sv | 90 +++++++++
 tb/tb_mem_port_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and load/store (D), one transaction at a time, with watchdog abort.
// Define ARB_ROUND_ROBIN_EN to alternate owners on ties; otherwise D wins every tie.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        r_state;
    logic          r_sel;
    logic [CW-1:0] r_cnt;
    logic          w_busy_i, w_busy_d, w_busy, w_first, w_abort, w_done, w_win_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last;
    // r_last = 1 means D owned the port last; a tie goes to the other side
    assign w_win_d = d_req && (!i_req || !r_last);
`else
    assign w_win_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_cnt   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last  <= 1'b1;
`endif
        end else if (r_state == IDLE) begin
            if (i_req || d_req) begin
                r_state <= w_win_d ? BUSY_D : BUSY_I;
                r_sel   <= w_win_d;
                r_cnt   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                r_last  <= w_win_d;
`endif
            end
        end else if (w_done) begin
            r_state <= IDLE;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_busy_i  = r_state == BUSY_I;
    assign w_busy_d  = r_state == BUSY_D;
    assign w_busy    = w_busy_i || w_busy_d;
    assign w_first   = w_busy && r_cnt == '0;
    assign w_abort   = w_busy && !mem_ready && r_cnt == LAST;
    assign w_done    = w_busy && (mem_ready || r_cnt == LAST);

    assign sel       = r_sel;
    assign i_gnt     = w_first && w_busy_i;
    assign d_gnt     = w_first && w_busy_d;
    assign i_rvalid  = w_done && w_busy_i;
    assign d_rvalid  = w_done && w_busy_d;
    assign i_rdata   = (w_busy_i && mem_ready) ? mem_rdata : '0;
    assign d_rdata   = (w_busy_d && mem_ready) ? mem_rdata : '0;
    assign err       = w_abort;
    assign mem_req   = w_busy;
    assign mem_we    = w_busy_d && d_we;
    assign mem_addr  = w_busy ? (r_sel ? d_addr : i_addr) : '0;
    assign mem_wdata = w_busy_d ? d_wdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transactions against a transaction-level model of the arbiter.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;
    localparam int TIMEOUT = 16;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, err, sel, mem_req, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .err(err), .sel(sel), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model: pending requests per requester and which side owned the port last
    bit          pend_i = 1'b0, pend_d = 1'b0, last_d = 1'b1, we_m = 1'b0;
    logic [31:0] a_i = '0, a_d = '0, wd_m = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"}, 32'({i_gnt, d_gnt}), 32'd0);
        check({tag, "_rvalid"}, 32'({i_rvalid, d_rvalid, err}), 32'd0);
        check({tag, "_memctl"}, 32'({mem_req, mem_we}), 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_rdata"}, i_rdata | d_rdata, 32'd0);
    endtask

    // One IDLE cycle (new requests join the pending set) followed by the BUSY cycles of one transaction.
    // lat = BUSY cycle index (from 0) on which mem_ready is raised; >= TIMEOUT never answers.
    task automatic txn(input bit ni, input bit nd, input int lat,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] dw, input bit dwe);
        bit          win_d, done, ok;
        logic [31:0] data;
        @(posedge clk); #1;
        if (ni && !pend_i) begin pend_i = 1'b1; a_i = ia; end
        if (nd && !pend_d) begin pend_d = 1'b1; a_d = da; wd_m = dw; we_m = dwe; end
        if (!pend_i && !pend_d) begin pend_i = 1'b1; a_i = ia; end
        i_req = pend_i; i_addr = a_i;
        d_req = pend_d; d_addr = a_d; d_wdata = wd_m; d_we = we_m;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1 check_idle("idle");
        win_d = (pend_i && pend_d) ? (RR ? !last_d : 1'b1) : pend_d;
        last_d = win_d;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(posedge clk); #1;
            mem_ready = (k == lat);
            data = $urandom;
            mem_rdata = data;
            ok = (k == lat);
            done = ok || (k == TIMEOUT - 1);
            #1;
            check("sel", 32'(sel), 32'(win_d));
            check("mem_req", 32'(mem_req), 32'd1);
            check("gnt", 32'({i_gnt, d_gnt}), (k == 0) ? (win_d ? 32'd1 : 32'd2) : 32'd0);
            check("rvalid", 32'({i_rvalid, d_rvalid}), done ? (win_d ? 32'd1 : 32'd2) : 32'd0);
            check("i_rdata", i_rdata, (done && ok && !win_d) ? data : 32'd0);
            check("d_rdata", d_rdata, (done && ok && win_d) ? data : 32'd0);
            check("err", 32'(err), 32'(done && !ok));
            check("mem_addr", mem_addr, win_d ? a_d : a_i);
            check("mem_we", 32'(mem_we), 32'(win_d && we_m));
            check("mem_wdata", mem_wdata, win_d ? wd_m : 32'd0);
            if (done) break;
        end
        if (win_d) pend_d = 1'b0; else pend_i = 1'b0;
    endtask

    task automatic drain();
        while (pend_i || pend_d) txn(1'b0, 1'b0, 1, $urandom, $urandom, $urandom, 1'b0);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_idle("reset");
        check("reset_sel", 32'(sel), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        txn(1'b1, 1'b0, 2, 32'h100, 32'h0, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 0, 32'h0, 32'h200, 32'h55AA, 1'b1);
        repeat (4) txn(1'b1, 1'b1, 0, $urandom, $urandom, $urandom, 1'($urandom));
        drain();
        txn(1'b0, 1'b1, 1000, 32'h0, 32'h300, 32'h0, 1'b0);
        drain();

        // reset in the second BUSY cycle abandons the transaction
        @(posedge clk); #1;
        d_req = 1'b1; d_addr = 32'h400; d_we = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; d_req = 1'b0; mem_ready = 1'b1;
        #1 check_idle("after_reset");
        check("after_reset_sel", 32'(sel), 32'd0);
        mem_ready = 1'b0;
        last_d = 1'b1;
        txn(1'b1, 1'b0, 1, 32'h500, 32'h0, 32'h0, 1'b0);
        drain();

        // mem_ready while idle with no requests does nothing
        @(posedge clk); #1;
        mem_ready = 1'b1;
        #1 check_idle("idle_ready");
        @(posedge clk); #2;
        check_idle("idle_stay");
        mem_ready = 1'b0;

        repeat (150) begin
            int lat;
            lat = ($urandom_range(0, 9) == 0) ? TIMEOUT + 4 : int'($urandom_range(0, 5));
            txn(1'($urandom), 1'($urandom), lat, $urandom, $urandom, $urandom, 1'($urandom));
        end
        drain();
        @(posedge clk); #2;
        check_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
